// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers for the synchronous FIFO slice.
// addr_width(depth) gives the storage address width.
// ptr_width(depth) adds one wrap bit on top of that.
package fifo_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 8;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // The extra MSB separates "full" from "empty" when the low bits match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_memory.sv
// fifo_memory: simple dual-port storage array with a registered read port.
// It has no reset, so the array and dout_o power up undefined.
//   wr_clk_i, write_en_i, write_addr_i, din_i : write port
//   rd_clk_i, read_en_i, read_addr_i          : read port
//   dout_o : read data, one cycle after read_en_i
//   vld_o  : read_en_i delayed by one cycle
// A read and a write to the same address in one cycle return the old word.
module fifo_memory
    import fifo_pkg::*;
#(
    parameter  int depth = DEF_DEPTH,
    parameter  int width = DEF_WIDTH,
    localparam int AW    = addr_width(depth)
) (
    input  logic             wr_clk_i,
    input  logic             write_en_i,
    input  logic [AW-1:0]    write_addr_i,
    input  logic [width-1:0] din_i,
    input  logic             rd_clk_i,
    input  logic             read_en_i,
    input  logic [AW-1:0]    read_addr_i,
    output logic [width-1:0] dout_o,
    output logic             vld_o
);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] dout_q;
    logic             vld_q;

    always_ff @(posedge wr_clk_i) begin
        if (write_en_i) begin
            mem_q[write_addr_i] <= din_i;
        end
    end

    always_ff @(posedge rd_clk_i) begin
        vld_q <= read_en_i;
        if (read_en_i) begin
            dout_q <= mem_q[read_addr_i];
        end
    end

    assign dout_o = dout_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO control wrapped around fifo_memory.
// It owns the read and write pointers, the occupancy flags, the sticky error
// bits and the read-valid pulse.
//   clk, rst                     : clock, asynchronous active-high reset
//   wr_en, din                   : write request and data
//   rd_en                        : read request
//   dout, dout_vld               : read data and its one-cycle valid pulse
//   full, empty, almost_full,
//   almost_empty, count          : occupancy, decoded from registers only
//   overflow, underflow, clr_err : sticky errors and their synchronous clear
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int AF_THRESH = 6,
    parameter  int AE_THRESH = 2,
    localparam int AW        = addr_width(DEPTH),
    localparam int PW        = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [PW-1:0] AF_CMP = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_CMP = PW'(AE_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          dout_vld_q;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_acc, wr_acc;
    logic          mem_vld_unused;

    // Flags come from the pointer registers only, with no path from the requests.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_CMP);
    assign almost_empty = (count <= AE_CMP);

    // A write to a full FIFO goes through when a read frees a slot in the
    // same cycle. An empty FIFO never bypasses a write to the read port.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        // A new error sets the bit even when clr_err is asserted in the same cycle.
        ovf_d = (wr_en & ~wr_acc) | (ovf_q & ~clr_err);
        udf_d = (rd_en & empty)   | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dout_vld_q <= rd_acc;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign dout_vld  = dout_vld_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    // The memory's own vld output is not used. dout_vld is kept here so that
    // reset clears it, including a read that is still in flight.
    fifo_memory #(
        .depth (DEPTH),
        .width (WIDTH)
    ) u_mem (
        .wr_clk_i     (clk),
        .write_en_i   (wr_acc),
        .write_addr_i (wr_ptr_q[AW-1:0]),
        .din_i        (din),
        .rd_clk_i     (clk),
        .read_en_i    (rd_acc),
        .read_addr_i  (rd_ptr_q[AW-1:0]),
        .dout_o       (dout),
        .vld_o        (mem_vld_unused)
    );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_vld, full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    sync_fifo_ctrl #(.DEPTH(8), .WIDTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
        step();
        step();
        rst = 1'b0;
        step();

        // 1: reset and idle
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);
        check("rst_vld", dout_vld, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);

        // 2: fill with 0x01..0x08, then drain
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; din = 8'(i);
            step();
            check("fill_count", count, i);
            check("fill_afull", almost_full, (i >= 6) ? 1 : 0);
            check("fill_aempty", almost_empty, (i <= 2) ? 1 : 0);
            check("fill_full", full, (i == 8) ? 1 : 0);
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            step();
            check("drain_vld", dout_vld, 1);
            check("drain_data", dout, i);
            check("drain_count", count, 8 - i);
        end
        rd_en = 1'b0;
        step();
        check("drain_vld_end", dout_vld, 0);
        check("drain_empty", empty, 1);

        // 3: overflow while full, sticky over clr_err, then clear
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = 8'h11 + 8'(i);
            exp_q.push_back(8'h11 + 8'(i));
            step();
        end
        check("ovf_full", full, 1);
        din = 8'hAA;
        step();
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 8);
        clr_err = 1'b1;
        step();
        check("ovf_set_wins", overflow, 1);
        wr_en = 1'b0;
        step();
        check("ovf_cleared", overflow, 0);
        clr_err = 1'b0;

        // 5: full, write+read every cycle across pointer wrap
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 8'h20 + 8'(i);
            exp_q.push_back(8'h20 + 8'(i));
            step();
            exp_b = exp_q.pop_front();
            check("wrap_vld", dout_vld, 1);
            check("wrap_data", dout, exp_b);
            check("wrap_count", count, 8);
            check("wrap_ovf", overflow, 0);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            exp_b = exp_q.pop_front();
            check("wrap_drain_data", dout, exp_b);
        end
        rd_en = 1'b0;
        step();
        check("wrap_drain_empty", empty, 1);

        // 4: read while empty with a simultaneous write, no bypass
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
        step();
        check("udf_set", underflow, 1);
        check("udf_count", count, 1);
        check("udf_vld", dout_vld, 0);
        wr_en = 1'b0;
        step();
        check("udf_read_vld", dout_vld, 1);
        check("udf_read_data", dout, 8'h55);
        check("udf_sticky", underflow, 1);
        rd_en = 1'b0; clr_err = 1'b1;
        step();
        check("udf_cleared", underflow, 0);
        clr_err = 1'b0;

        // 6: reset with count=5 and a read in flight
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; din = 8'h70 + 8'(i);
            step();
        end
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h7F;
        step();
        check("inflight_count", count, 5);
        check("inflight_vld", dout_vld, 1);
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_vld", dout_vld, 0);
        step();
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_vld", dout_vld, 0);
        check("mid_rst_aempty", almost_empty, 1);
        rst = 1'b0;
        step();
        check("post_rst_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
